// File: rtl/hazard_forward_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hazard_pkg
// Brief   : Shared stall-cause state and forward-select encodings.
// Revision: 1.0
// ============================================================================
package hazard_pkg;

  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_LOAD_STALL = 2'd1;
  localparam logic [1:0] ST_MC_STALL   = 2'd2;

  localparam int FWD_NONE = 0;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_forward_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : hazard_forward_unit_if
// Brief   : Pipeline-side bundle between the core and the hazard/forward unit.
// Revision: 1.0
// ============================================================================
interface hazard_forward_unit_if #(
  parameter int AW         = 5,
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 2,
  parameter int SEL_W      = $clog2(FWD_STAGES + 1),
  parameter int CNT_W      = 32
);

  logic [NUM_SRC*AW-1:0]    SRC_ADDR;
  logic [NUM_SRC-1:0]       SRC_USE;
  logic [AW-1:0]            ID_DEST;
  logic                     ID_DEST_VALID;
  logic [FWD_STAGES*AW-1:0] STAGE_ADDR;
  logic [FWD_STAGES-1:0]    STAGE_REGWRITE_EN;
  logic                     STAGE3_MEM_READ;
  logic                     MC_ISSUE;
  logic [AW-1:0]            MC_DEST;
  logic                     MC_DONE;
  logic [AW-1:0]            MC_DONE_DEST;
  logic [NUM_SRC*SEL_W-1:0] OP_MUX_OUT;
  logic                     STALL;
  logic                     BUBBLE;
  logic [1:0]               STALL_STATE;
  logic [CNT_W-1:0]         LU_STALL_CNT;
  logic [CNT_W-1:0]         MC_STALL_CNT;

  modport master (
    output SRC_ADDR, SRC_USE, ID_DEST, ID_DEST_VALID, STAGE_ADDR,
           STAGE_REGWRITE_EN, STAGE3_MEM_READ, MC_ISSUE, MC_DEST,
           MC_DONE, MC_DONE_DEST,
    input  OP_MUX_OUT, STALL, BUBBLE, STALL_STATE, LU_STALL_CNT, MC_STALL_CNT
  );

  modport slave (
    input  SRC_ADDR, SRC_USE, ID_DEST, ID_DEST_VALID, STAGE_ADDR,
           STAGE_REGWRITE_EN, STAGE3_MEM_READ, MC_ISSUE, MC_DEST,
           MC_DONE, MC_DONE_DEST,
    output OP_MUX_OUT, STALL, BUBBLE, STALL_STATE, LU_STALL_CNT, MC_STALL_CNT
  );

endinterface : hazard_forward_unit_if
`default_nettype wire

// File: rtl/hazard_forward_unit_fwd_select.sv
`default_nettype none
// ============================================================================
// Module  : fwd_select
// Brief   : Priority match of one source operand against the producing stages.
// Revision: 1.0
// ============================================================================
module fwd_select
  import hazard_pkg::*;
#(
  parameter int AW         = 5,
  parameter int FWD_STAGES = 2,
  parameter int SEL_W      = $clog2(FWD_STAGES + 1)
) (
  input  wire logic [AW-1:0]            src_addr,
  input  wire logic                     src_use,
  input  wire logic [FWD_STAGES*AW-1:0] stage_addr,
  input  wire logic [FWD_STAGES-1:0]    stage_we,
  output logic      [SEL_W-1:0]         sel
);

  // Scan farthest to nearest so the nearest matching stage wins.
  always_comb begin
    sel = SEL_W'(FWD_NONE);
    if (src_use && (src_addr != '0)) begin
      for (int k = FWD_STAGES - 1; k >= 0; k--) begin
        if (stage_we[k] && (stage_addr[k*AW +: AW] == src_addr)) begin
          sel = SEL_W'(k + 1);
        end
      end
    end
  end

endmodule : fwd_select
`default_nettype wire

// File: rtl/hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module  : hazard_forward_unit
// Brief   : Operand forwarding, load-use/MC stall detection, scoreboard, stall FSM.
// Revision: 1.0
// ============================================================================
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int AW         = 5,
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 2,
  parameter int SEL_W      = $clog2(FWD_STAGES + 1),
  parameter int CNT_W      = 32
) (
  input wire logic           CLK,
  input wire logic           RESET,
  hazard_forward_unit_if.slave bus
);

  localparam int NREG = 2 ** AW;

  logic [NUM_SRC*SEL_W-1:0] sel_raw;
  logic [NUM_SRC-1:0]       lu_hit;
  logic [NUM_SRC-1:0]       mc_hit;
  logic [NREG-1:0]          pending;
  logic [NREG-1:0]          pending_nxt;
  logic                     lu_hazard;
  logic                     mc_hazard;
  logic [1:0]               state;
  logic [1:0]               state_nxt;
  logic [CNT_W-1:0]         lu_cnt;
  logic [CNT_W-1:0]         mc_cnt;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [AW-1:0] addr;
    assign addr = bus.SRC_ADDR[i*AW +: AW];

    fwd_select #(
      .AW         (AW),
      .FWD_STAGES (FWD_STAGES),
      .SEL_W      (SEL_W)
    ) u_fwd_select (
      .src_addr   (addr),
      .src_use    (bus.SRC_USE[i]),
      .stage_addr (bus.STAGE_ADDR),
      .stage_we   (bus.STAGE_REGWRITE_EN),
      .sel        (sel_raw[i*SEL_W +: SEL_W])
    );

    assign lu_hit[i] = bus.SRC_USE[i] && (addr != '0) && (addr == bus.STAGE_ADDR[AW-1:0]);
    assign mc_hit[i] = bus.SRC_USE[i] && pending[addr];
  end

  assign lu_hazard = bus.STAGE3_MEM_READ && bus.STAGE_REGWRITE_EN[0] && (|lu_hit);
  assign mc_hazard = (|mc_hit) || (bus.ID_DEST_VALID && pending[bus.ID_DEST]);

  // Issue is applied after done so a same-register collision leaves the bit set.
  always_comb begin
    pending_nxt = pending;
    if (bus.MC_DONE) begin
      pending_nxt[bus.MC_DONE_DEST] = 1'b0;
    end
    if (bus.MC_ISSUE && (bus.MC_DEST != '0)) begin
      pending_nxt[bus.MC_DEST] = 1'b1;
    end
  end

  always_comb begin
    state_nxt = ST_RUN;
    if (lu_hazard) begin
      state_nxt = ST_LOAD_STALL;
    end else if (mc_hazard) begin
      state_nxt = ST_MC_STALL;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pending <= '0;
      state   <= ST_RUN;
      lu_cnt  <= '0;
      mc_cnt  <= '0;
    end else begin
      pending <= pending_nxt;
      state   <= state_nxt;
      if (lu_hazard && (lu_cnt != '1)) begin
        lu_cnt <= lu_cnt + CNT_W'(1);
      end
      if (mc_hazard && !lu_hazard && (mc_cnt != '1)) begin
        mc_cnt <= mc_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.OP_MUX_OUT   = RESET ? '0 : sel_raw;
  assign bus.STALL        = !RESET && (lu_hazard || mc_hazard);
  assign bus.BUBBLE       = !RESET && (lu_hazard || mc_hazard);
  assign bus.STALL_STATE  = state;
  assign bus.LU_STALL_CNT = lu_cnt;
  assign bus.MC_STALL_CNT = mc_cnt;

endmodule : hazard_forward_unit
`default_nettype wire

// File: tb/tb_hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_hazard_forward_unit
// Brief   : Self-checking bench with a behavioural reference model.
// Revision: 1.0
// ============================================================================
module tb_hazard_forward_unit;

  localparam int AW         = 5;
  localparam int NUM_SRC    = 2;
  localparam int FWD_STAGES = 2;
  localparam int SEL_W      = $clog2(FWD_STAGES + 1);
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_forward_unit_if #(
    .AW(AW), .NUM_SRC(NUM_SRC), .FWD_STAGES(FWD_STAGES), .SEL_W(SEL_W), .CNT_W(CNT_W)
  ) bus ();

  hazard_forward_unit #(
    .AW(AW), .NUM_SRC(NUM_SRC), .FWD_STAGES(FWD_STAGES), .SEL_W(SEL_W), .CNT_W(CNT_W)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Stimulus variables
  logic [AW-1:0] src_a [NUM_SRC];
  bit            src_u [NUM_SRC];
  logic [AW-1:0] st_a  [FWD_STAGES];
  bit            st_we [FWD_STAGES];
  bit            mem_rd, id_v, mc_issue, mc_done;
  logic [AW-1:0] id_dest, mc_dest, mc_done_dest;

  // Reference model state
  bit m_pend [1 << AW];
  int m_state, m_lu, m_mc;

  function automatic int m_sel(int i);
    if (rst || !src_u[i] || src_a[i] == 0) return 0;
    for (int k = 0; k < FWD_STAGES; k++)
      if (st_we[k] && st_a[k] == src_a[i]) return k + 1;
    return 0;
  endfunction

  function automatic bit m_lu_haz();
    if (!mem_rd || !st_we[0]) return 0;
    for (int i = 0; i < NUM_SRC; i++)
      if (src_u[i] && src_a[i] != 0 && src_a[i] == st_a[0]) return 1;
    return 0;
  endfunction

  function automatic bit m_mc_haz();
    for (int i = 0; i < NUM_SRC; i++)
      if (src_u[i] && m_pend[src_a[i]]) return 1;
    return id_v && m_pend[id_dest];
  endfunction

  function automatic bit m_stall();
    return !rst && (m_lu_haz() || m_mc_haz());
  endfunction

  task automatic drive();
    for (int i = 0; i < NUM_SRC; i++) begin
      bus.SRC_ADDR[i*AW +: AW] = src_a[i];
      bus.SRC_USE[i]           = src_u[i];
    end
    for (int k = 0; k < FWD_STAGES; k++) begin
      bus.STAGE_ADDR[k*AW +: AW] = st_a[k];
      bus.STAGE_REGWRITE_EN[k]   = st_we[k];
    end
    bus.STAGE3_MEM_READ = mem_rd;
    bus.ID_DEST         = id_dest;
    bus.ID_DEST_VALID   = id_v;
    bus.MC_ISSUE        = mc_issue;
    bus.MC_DEST         = mc_dest;
    bus.MC_DONE         = mc_done;
    bus.MC_DONE_DEST    = mc_done_dest;
  endtask

  task automatic idle();
    for (int i = 0; i < NUM_SRC; i++) begin src_a[i] = '0; src_u[i] = 0; end
    for (int k = 0; k < FWD_STAGES; k++) begin st_a[k] = '0; st_we[k] = 0; end
    mem_rd = 0; id_v = 0; id_dest = '0;
    mc_issue = 0; mc_dest = '0; mc_done = 0; mc_done_dest = '0;
  endtask

  // Advance one clock, updating the model from the inputs of the ending cycle.
  task automatic tick();
    bit lu, mc;
    lu = m_lu_haz();
    mc = m_mc_haz();
    @(posedge clk);
    if (rst) begin
      foreach (m_pend[r]) m_pend[r] = 0;
      m_state = 0; m_lu = 0; m_mc = 0;
    end else begin
      m_state = lu ? 1 : (mc ? 2 : 0);
      if (lu && m_lu < CNT_MAX) m_lu++;
      if (mc && !lu && m_mc < CNT_MAX) m_mc++;
      if (mc_done) m_pend[mc_done_dest] = 0;
      if (mc_issue && mc_dest != 0) m_pend[mc_dest] = 1;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1; idle(); drive();
    tick(); tick();
    rst = 0; drive();
  endtask

  task automatic test_reset();
    rst = 1; idle();
    src_a[0] = 5; src_u[0] = 1; st_a[0] = 5; st_we[0] = 1; mem_rd = 1;
    drive();
    @(negedge clk);
    n_checks++;
    if (bus.OP_MUX_OUT !== '0) begin n_fails++; $display("FAIL reset_sel: got %0d expected 0", bus.OP_MUX_OUT); end
    n_checks++;
    if (bus.STALL !== 1'b0 || bus.BUBBLE !== 1'b0) begin n_fails++; $display("FAIL reset_stall: got %b/%b expected 0/0", bus.STALL, bus.BUBBLE); end
    tick(); tick();
    n_checks++;
    if (bus.STALL_STATE !== 2'd0 || bus.LU_STALL_CNT !== '0 || bus.MC_STALL_CNT !== '0) begin
      n_fails++; $display("FAIL reset_regs: got state %0d lu %0d mc %0d expected 0 0 0",
                          bus.STALL_STATE, bus.LU_STALL_CNT, bus.MC_STALL_CNT);
    end
    rst = 0; idle(); drive();
  endtask

  task automatic test_forwarding();
    idle();
    src_a[0] = 5; src_u[0] = 1;
    st_a[0] = 5; st_we[0] = 1; st_a[1] = 5; st_we[1] = 1;
    drive(); @(negedge clk);
    n_checks++;
    if (bus.OP_MUX_OUT[SEL_W-1:0] !== 2'd1) begin n_fails++; $display("FAIL fwd_nearest: got %0d expected 1", bus.OP_MUX_OUT[SEL_W-1:0]); end
    tick();
    st_we[0] = 0; drive(); @(negedge clk);
    n_checks++;
    if (bus.OP_MUX_OUT[SEL_W-1:0] !== 2'd2) begin n_fails++; $display("FAIL fwd_far: got %0d expected 2", bus.OP_MUX_OUT[SEL_W-1:0]); end
    tick();
    src_u[0] = 0; drive(); @(negedge clk);
    n_checks++;
    if (bus.OP_MUX_OUT[SEL_W-1:0] !== 2'd0) begin n_fails++; $display("FAIL fwd_unused: got %0d expected 0", bus.OP_MUX_OUT[SEL_W-1:0]); end
    tick();
    idle();
    src_a[1] = 0; src_u[1] = 1; st_a[0] = 0; st_we[0] = 1; mem_rd = 1;
    drive(); @(negedge clk);
    n_checks++;
    if (bus.OP_MUX_OUT[SEL_W +: SEL_W] !== 2'd0) begin n_fails++; $display("FAIL fwd_x0: got %0d expected 0", bus.OP_MUX_OUT[SEL_W +: SEL_W]); end
    n_checks++;
    if (bus.STALL !== 1'b0) begin n_fails++; $display("FAIL x0_stall: got %b expected 0", bus.STALL); end
    tick();
    idle(); drive();
  endtask

  task automatic test_load_use();
    do_reset();
    idle();
    src_a[0] = 7; src_u[0] = 1; st_a[0] = 7; st_we[0] = 1; mem_rd = 1;
    drive(); @(negedge clk);
    n_checks++;
    if (bus.STALL !== 1'b1 || bus.BUBBLE !== 1'b1) begin n_fails++; $display("FAIL lu_stall: got %b/%b expected 1/1", bus.STALL, bus.BUBBLE); end
    tick();
    n_checks++;
    if (bus.STALL_STATE !== 2'd1) begin n_fails++; $display("FAIL lu_state: got %0d expected 1", bus.STALL_STATE); end
    st_we[0] = 0; st_a[0] = 0; mem_rd = 0; st_a[1] = 7; st_we[1] = 1;
    drive(); @(negedge clk);
    n_checks++;
    if (bus.OP_MUX_OUT[SEL_W-1:0] !== 2'd2 || bus.STALL !== 1'b0) begin
      n_fails++; $display("FAIL lu_release: got sel %0d stall %b expected 2 0", bus.OP_MUX_OUT[SEL_W-1:0], bus.STALL);
    end
    tick();
    n_checks++;
    if (bus.LU_STALL_CNT !== 4'd1 || bus.STALL_STATE !== 2'd0) begin
      n_fails++; $display("FAIL lu_count: got cnt %0d state %0d expected 1 0", bus.LU_STALL_CNT, bus.STALL_STATE);
    end
    idle(); drive();
  endtask

  task automatic test_mc_stall();
    int bad;
    do_reset();
    idle(); mc_issue = 1; mc_dest = 9; drive(); tick();
    idle(); src_a[0] = 9; src_u[0] = 1;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      drive(); @(negedge clk);
      if (bus.STALL !== 1'b1) bad++;
      tick();
    end
    n_checks++;
    if (bad != 0) begin n_fails++; $display("FAIL mc_hold: got %0d non-stall cycles expected 0", bad); end
    n_checks++;
    if (bus.STALL_STATE !== 2'd2) begin n_fails++; $display("FAIL mc_state: got %0d expected 2", bus.STALL_STATE); end
    mc_done = 1; mc_done_dest = 9; drive(); @(negedge clk);
    n_checks++;
    if (bus.STALL !== 1'b1) begin n_fails++; $display("FAIL mc_done_cycle: got %b expected 1", bus.STALL); end
    tick();
    mc_done = 0; drive(); @(negedge clk);
    n_checks++;
    if (bus.STALL !== 1'b0) begin n_fails++; $display("FAIL mc_release: got %b expected 0", bus.STALL); end
    tick();
    n_checks++;
    if (bus.MC_STALL_CNT !== 4'd5) begin n_fails++; $display("FAIL mc_count: got %0d expected 5", bus.MC_STALL_CNT); end
    idle(); drive();
  endtask

  task automatic test_issue_done_same();
    do_reset();
    idle(); mc_issue = 1; mc_dest = 3; mc_done = 1; mc_done_dest = 3; drive(); tick();
    idle(); id_dest = 3; id_v = 1; drive(); @(negedge clk);
    n_checks++;
    if (bus.STALL !== 1'b1) begin n_fails++; $display("FAIL set_wins_waw: got %b expected 1", bus.STALL); end
    tick();
    idle(); mc_issue = 1; mc_dest = 0; drive(); tick();
    idle(); src_a[0] = 0; src_u[0] = 1; drive(); @(negedge clk);
    n_checks++;
    if (bus.STALL !== 1'b0) begin n_fails++; $display("FAIL x0_never_pending: got %b expected 0", bus.STALL); end
    tick();
    idle(); drive();
  endtask

  task automatic test_reset_and_saturation();
    do_reset();
    idle(); mc_issue = 1; mc_dest = 9; drive(); tick();
    idle(); src_a[0] = 9; src_u[0] = 1; drive(); tick(); tick();
    rst = 1; drive(); @(negedge clk);
    n_checks++;
    if (bus.STALL !== 1'b0) begin n_fails++; $display("FAIL mid_reset_stall: got %b expected 0", bus.STALL); end
    tick();
    rst = 0; drive(); @(negedge clk);
    n_checks++;
    if (bus.STALL !== 1'b0 || bus.STALL_STATE !== 2'd0 || bus.MC_STALL_CNT !== '0) begin
      n_fails++; $display("FAIL after_reset: got stall %b state %0d mc %0d expected 0 0 0",
                          bus.STALL, bus.STALL_STATE, bus.MC_STALL_CNT);
    end
    tick();
    idle(); src_a[1] = 6; src_u[1] = 1; st_a[0] = 6; st_we[0] = 1; mem_rd = 1; drive();
    for (int c = 0; c < CNT_MAX + 5; c++) tick();
    n_checks++;
    if (bus.LU_STALL_CNT !== 4'd15 || bus.STALL_STATE !== 2'd1) begin
      n_fails++; $display("FAIL lu_saturate: got cnt %0d state %0d expected 15 1", bus.LU_STALL_CNT, bus.STALL_STATE);
    end
    idle(); mc_issue = 1; mc_dest = 4; drive(); tick();
    idle(); id_dest = 4; id_v = 1; drive();
    for (int c = 0; c < CNT_MAX + 5; c++) tick();
    n_checks++;
    if (bus.MC_STALL_CNT !== 4'd15 || bus.LU_STALL_CNT !== 4'd15) begin
      n_fails++; $display("FAIL mc_saturate: got mc %0d lu %0d expected 15 15", bus.MC_STALL_CNT, bus.LU_STALL_CNT);
    end
    idle(); drive();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < NUM_SRC; i++) begin
        src_a[i] = AW'($urandom_range(0, 7)); src_u[i] = ($urandom_range(0, 3) != 0);
      end
      for (int k = 0; k < FWD_STAGES; k++) begin
        st_a[k] = AW'($urandom_range(0, 7)); st_we[k] = $urandom_range(0, 1);
      end
      mem_rd = ($urandom_range(0, 3) == 0);
      id_dest = AW'($urandom_range(0, 7)); id_v = $urandom_range(0, 1);
      mc_issue = ($urandom_range(0, 3) == 0); mc_dest = AW'($urandom_range(0, 7));
      mc_done = ($urandom_range(0, 2) == 0); mc_done_dest = AW'($urandom_range(0, 7));
      drive(); @(negedge clk);
      for (int i = 0; i < NUM_SRC; i++) begin
        n_checks++;
        if (int'(bus.OP_MUX_OUT[i*SEL_W +: SEL_W]) != m_sel(i)) begin
          n_fails++; $display("FAIL rnd_sel%0d cyc %0d: got %0d expected %0d", i, c, bus.OP_MUX_OUT[i*SEL_W +: SEL_W], m_sel(i));
        end
      end
      n_checks++;
      if (bus.STALL !== m_stall() || bus.BUBBLE !== m_stall()) begin
        n_fails++; $display("FAIL rnd_stall cyc %0d: got %b/%b expected %b", c, bus.STALL, bus.BUBBLE, m_stall());
      end
      tick();
      n_checks++;
      if (int'(bus.STALL_STATE) != m_state || int'(bus.LU_STALL_CNT) != m_lu || int'(bus.MC_STALL_CNT) != m_mc) begin
        n_fails++; $display("FAIL rnd_regs cyc %0d: got %0d/%0d/%0d expected %0d/%0d/%0d", c,
                            bus.STALL_STATE, bus.LU_STALL_CNT, bus.MC_STALL_CNT, m_state, m_lu, m_mc);
      end
    end
    rst = 0; idle(); drive();
  endtask

  initial begin
    foreach (m_pend[r]) m_pend[r] = 0;
    m_state = 0; m_lu = 0; m_mc = 0;
    idle(); drive();
    #1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_mc_stall();
    test_issue_done_same();
    test_reset_and_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_hazard_forward_unit
`default_nettype wire

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Parametrised hazard and forwarding unit for the pipelined CPU core, sitting beside the stage-3 (EX) operand multiplexers and the ID/EX pipeline register. It generalises operand forwarding to `NUM_SRC` source operands and `FWD_STAGES` producing stages. It adds load-use stall detection, a per-register scoreboard for the multi-cycle unit (MUL/DIV), a stall-cause state machine and saturating stall counters.

## Interface
- `AW`, default 5: register address width; the register file has 2^AW registers.
- `NUM_SRC`, default 2: number of source operands checked.
- `FWD_STAGES`, default 2: number of producing stages. Index 0 is stage 3 (nearest); the highest index is the farthest.
- `SEL_W`, default `$clog2(FWD_STAGES+1)`: width of each operand mux select.
- `CNT_W`, default 32: width of the stall counters.

Ports:
- `CLK`  in  1: clock.
- `RESET`  in  1: synchronous, active-high reset.
- `SRC_ADDR`  in  NUM_SRC*AW: source register addresses of the instruction entering stage 3, packed; operand i is `[i*AW +: AW]`.
- `SRC_USE`  in  NUM_SRC: operand i actually reads a register.
- `ID_DEST`  in  AW: destination register of the instruction in decode.
- `ID_DEST_VALID`  in  1: the decode instruction writes `ID_DEST`.
- `STAGE_ADDR`  in  FWD_STAGES*AW: destination register held in each producing stage.
- `STAGE_REGWRITE_EN`  in  FWD_STAGES: each producing stage will write back.
- `STAGE3_MEM_READ`  in  1: the stage-3 instruction is a load.
- `MC_ISSUE`  in  1: the multi-cycle unit accepts an operation this cycle.
- `MC_DEST`  in  AW: destination register of the issued operation.
- `MC_DONE`  in  1: the multi-cycle unit writes its result this cycle.
- `MC_DONE_DEST`  in  AW: destination register of the completing operation.
- `OP_MUX_OUT`  out  NUM_SRC*SEL_W: per-operand forward select. 0 means register file; k means stage index k-1.
- `STALL`  out  1: freeze PC and IF/ID.
- `BUBBLE`  out  1: load a NOP into ID/EX.
- `STALL_STATE`  out  2: 0 RUN, 1 LOAD_STALL, 2 MC_STALL.
- `LU_STALL_CNT`, `MC_STALL_CNT`  out  CNT_W each: saturating stall-cycle counters.

## Operation
- Forwarding: for each operand i with `SRC_USE[i]=1` and a source address other than 0, select the lowest stage index k where `STAGE_REGWRITE_EN[k]=1` and `STAGE_ADDR[k]` matches. Output k+1, or 0 when no stage matches. Register 0 never forwards. An operand with `SRC_USE[i]=0` selects 0.
- Load-use hazard: `STAGE3_MEM_READ=1`, `STAGE_REGWRITE_EN[0]=1`, and a used, nonzero source matches `STAGE_ADDR[0]`.
- Scoreboard: one pending bit per register.
  - `MC_ISSUE` with `MC_DEST` nonzero sets `pending[MC_DEST]`.
  - `MC_DONE` clears `pending[MC_DONE_DEST]`.
  - If issue and done name the same register in the same cycle, set wins.
  - Register 0 is never pending.
- MC hazard: any used source has its pending bit set, or `ID_DEST_VALID=1` and `pending[ID_DEST]=1` (a WAW hazard).
- `STALL` and `BUBBLE` are both asserted, combinationally, when a load-use hazard or an MC hazard exists.
- Stall-cause FSM, registered each cycle:
  - The next state is LOAD_STALL if a load-use hazard exists, else MC_STALL if an MC hazard exists, else RUN. Load-use takes priority.
  - A load-use stall lasts exactly one cycle. The bubble then sits in stage 3, so the load is in stage 4 and the forward select for that operand becomes 2.
- Counters: `LU_STALL_CNT` increments each cycle the load-use hazard exists. `MC_STALL_CNT` increments each cycle an MC hazard stalls without a load-use hazard. Both saturate at all-ones.

## Timing
- Selects, `STALL` and `BUBBLE` are combinational from the same-cycle inputs, with zero latency.
- Pending bits, FSM state and counters update on the rising edge of `CLK`.
- A pending bit cleared by `MC_DONE` stalls through the done cycle. The stall is released the next cycle, when the register file already holds the result.
- `RESET` takes priority over all other updates. It clears every pending bit, sets `STALL_STATE` to 0 (RUN) and zeroes both counters.
- While `RESET=1`, `OP_MUX_OUT`, `STALL` and `BUBBLE` are forced to 0.
- A reset arriving mid-stall takes effect at the next edge; the in-flight MC operation is discarded by the pipeline flush.

## Structure
- Shared package `hazard_pkg` holds the FSM state encoding (`ST_RUN`, `ST_LOAD_STALL`, `ST_MC_STALL`) and the select encoding `FWD_NONE=0`.
- Sub-module `fwd_select`: a combinational priority match for one operand, instantiated NUM_SRC times through a generate loop.
- The top level holds the scoreboard, the FSM and the counters.

## Test plan
- Stage 3 and stage 4 both write x5, and operand 0 reads x5 → the operand 0 select is 1; clear stage 3 → the select is 2.
- Operand 1 reads x0 while stage 3 writes x0 → the select is 0 and there is no stall.
- Stage 3 holds a load to x7 and operand 0 uses x7 → one cycle with `STALL=BUBBLE=1` and `STALL_STATE` 1. The next cycle (stage 3 bubble, stage 4 load) gives select 2 and `STALL` 0. `LU_STALL_CNT` is 1.
- `MC_ISSUE` to x9, then decode reads x9 for 4 cycles before `MC_DONE` for x9 → `STALL` stays 1 through the done cycle and drops the next cycle. `MC_STALL_CNT` is 5.
- `MC_ISSUE` x3 and `MC_DONE` x3 in the same cycle → x3 stays pending. With `ID_DEST` x3 and `ID_DEST_VALID=1` → `STALL=1`.
- Pulse `RESET` mid-MC-stall, then pre-load the counters and hold a hazard for 2^CNT_W cycles (with CNT_W=4) → after the reset the pending bits, state and counters are all 0. The counters hold at 15 with no wrap.
